// File: rtl/mem_arb_pkg.sv
// Shared types for the I/D memory port arbiter: FSM states, owner encoding and lane constants.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RDWAIT
  } arb_state_t;

  typedef enum logic {
    OWN_I,
    OWN_D
  } arb_owner_t;

  localparam logic [3:0] BE_ALL = 4'hF;

  function automatic arb_owner_t other_owner(input arb_owner_t o);
    return (o == OWN_I) ? OWN_D : OWN_I;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_arb_pick.sv
// Combinational winner select between the I and D requesters.
// ARB_ROUND_ROBIN_EN selects alternating priority on contention; otherwise D always wins.
module arb_pick
  import mem_arb_pkg::*;
(
  input  logic       req_i,
  input  logic       req_d,
  input  arb_owner_t last_owner,
  output logic       grant,
  output arb_owner_t winner
);

`ifdef ARB_ROUND_ROBIN_EN
  always_comb begin
    grant  = req_i | req_d;
    winner = OWN_D;
    if (req_i && req_d) begin
      winner = other_owner(last_owner);
    end else if (req_i) begin
      winner = OWN_I;
    end
  end
`else
  logic unused_last_owner;
  assign unused_last_owner = (last_owner == OWN_D);

  // D beats I whenever both are pending; the CPU guarantees fetches get a turn.
  always_comb begin
    grant  = req_i | req_d;
    winner = OWN_D;
    if (req_i && !req_d) begin
      winner = OWN_I;
    end
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares a single-port, registered-read word RAM between CPU fetch (I) and data (D) ports.
// Optional build macro ARB_ROUND_ROBIN_EN: alternate the winner on contention instead of D-first.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] i_address,
  input  logic              i_read,
  output logic              i_waitrequest,
  output logic [DATA_W-1:0] i_readdata,
  input  logic [ADDR_W-1:0] d_address,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [3:0]        d_byteenable,
  input  logic [DATA_W-1:0] d_writedata,
  output logic              d_waitrequest,
  output logic [DATA_W-1:0] d_readdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  output logic              mem_write,
  output logic [3:0]        mem_byteenable,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata
);

  arb_state_t        state_q, state_d;
  arb_owner_t        owner_q, owner_d;
  arb_owner_t        last_owner_q, last_owner_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        be_q, be_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  logic       grant;
  arb_owner_t winner;
  logic       done;

  // Byte offset within a word is dropped; misaligned requests simply hit the containing word.
  logic [3:0] unused_addr_bits;
  assign unused_addr_bits = {i_address[1:0], d_address[1:0]};

  arb_pick u_pick (
    .req_i      (i_read),
    .req_d      (d_read | d_write),
    .last_owner (last_owner_q),
    .grant      (grant),
    .winner     (winner)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      owner_q      <= OWN_I;
      last_owner_q <= OWN_I;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      be_q         <= '0;
      wdata_q      <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      be_q         <= be_d;
      wdata_q      <= wdata_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    wr_d         = wr_q;
    addr_d       = addr_q;
    be_d         = be_q;
    wdata_d      = wdata_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (grant) begin
          state_d      = ISSUE;
          owner_d      = winner;
          last_owner_d = winner;
          if (winner == OWN_D) begin
            // A simultaneous read+write from D is treated as the write.
            addr_d  = {2'b00, d_address[ADDR_W-1:2]};
            wr_d    = d_write;
            be_d    = d_byteenable;
            wdata_d = d_writedata;
          end else begin
            addr_d = {2'b00, i_address[ADDR_W-1:2]};
            wr_d   = 1'b0;
            be_d   = BE_ALL;
          end
        end
      end
      ISSUE: begin
        state_d = wr_q ? IDLE : RDWAIT;
      end
      RDWAIT: begin
        state_d = IDLE;
        if (owner_q == OWN_I) begin
          i_rdata_d = mem_readdata;
        end else begin
          d_rdata_d = mem_readdata;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    done           = ((state_q == ISSUE) && wr_q) || (state_q == RDWAIT);
    mem_address    = addr_q;
    mem_read       = (state_q == ISSUE) && !wr_q;
    mem_write      = (state_q == ISSUE) && wr_q;
    mem_byteenable = be_q;
    mem_writedata  = wdata_q;
    i_waitrequest  = !(done && (owner_q == OWN_I));
    d_waitrequest  = !(done && (owner_q == OWN_D));
    // Read data passes straight through on completion and is held afterwards.
    i_readdata     = ((state_q == RDWAIT) && (owner_q == OWN_I)) ? mem_readdata : i_rdata_q;
    d_readdata     = ((state_q == RDWAIT) && (owner_q == OWN_D)) ? mem_readdata : d_rdata_q;
  end

`ifndef SYNTHESIS
  d_rw_exclusive: assert property (@(posedge clk) disable iff (!reset_n) !(d_read && d_write))
    else $warning("mem_port_arbiter: d_read and d_write both high, write taken");
`endif

endmodule
